// File: rtl/n64_read_response.sv
// n64_read_response: N64 controller reply receiver; define N64_READ_STOP_CHECK_EN to also require the stop bit
module n64_read_response #(
    parameter int SAMPLE_PT = 200,
    parameter int BIT_GUARD = 300,
    parameter int TIMEOUT   = 1000,
    parameter int NBITS     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             begin_read,
    input  logic             data_in,
    output logic [NBITS-1:0] status_word,
    output logic             valid,
    output logic             busy,
    output logic             timeout_err
);
    localparam int IW = $clog2(NBITS + 1);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_FALL = 2'd1;
    localparam logic [1:0] BIT       = 2'd2;
`ifdef N64_READ_STOP_CHECK_EN
    localparam logic [1:0] STOP      = 2'd3;
`endif
    localparam logic [9:0] SAMPLE_AT = 10'(SAMPLE_PT - 1);
    localparam logic [9:0] GUARD_AT  = 10'(BIT_GUARD - 1);
    localparam logic [9:0] TMO_AT    = 10'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST   = IW'(NBITS - 1);

    logic             s1_q, s2_q, prev_q;
    logic [1:0]       state_q, state_d;
    logic [9:0]       cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NBITS-1:0] sh_q, sh_d, word_q, word_d;
    logic             valid_q, valid_d, tmo_q, tmo_d;
    logic             fall;

    assign fall        = prev_q & ~s2_q;
    assign cnt_inc     = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;
    assign status_word = word_q;
    assign valid       = valid_q;
    assign timeout_err = tmo_q;
    assign busy        = state_q != IDLE;

    // Next-state decode: wait for each falling edge, sample mid-bit, blank until the guard expires
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        idx_d   = idx_q;
        sh_d    = sh_q;
        word_d  = word_q;
        valid_d = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (begin_read) begin
                    state_d = WAIT_FALL;
                    idx_d   = '0;
                    sh_d    = '0;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    state_d = BIT;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_AT) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
            end
            BIT: begin
                if (cnt_q == SAMPLE_AT) sh_d = {sh_q[NBITS-2:0], s2_q};
                if (cnt_q == GUARD_AT) begin
                    cnt_d = '0;
                    if (idx_q == LAST) begin
`ifdef N64_READ_STOP_CHECK_EN
                        state_d = STOP;
`else
                        state_d = IDLE;
                        word_d  = sh_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        state_d = WAIT_FALL;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
`ifdef N64_READ_STOP_CHECK_EN
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    word_d  = sh_q;
                    valid_d = 1'b1;
                end else if (cnt_q == TMO_AT) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Registers: synchronizer idles high, everything else clears on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            s1_q    <= data_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule
